// File: rtl/axi_sram_lat.sv
// AXI-lite-style on-chip SRAM slave with independent, fixed read/write response latency,
// back-pressure and SLVERR responses for addresses outside the array window.
module axi_sram_lat #(
  parameter int unsigned         DATA_LEN  = 32,
  parameter int unsigned         STORB_LEN = DATA_LEN / 8,
  parameter int unsigned         ADDR_LEN  = 32,
  parameter int unsigned         DEPTH     = 1024,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned         READ_LAT  = 2,
  parameter int unsigned         WRITE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_LEN-1:0]  waddr,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATA_LEN-1:0]  wdata,
  input  logic [STORB_LEN-1:0] wstrob,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [2:0]           bresp,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_LEN-1:0]  raddr,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_LEN-1:0]  rdata,
  output logic [2:0]           rresp
);

  localparam int unsigned OFFB = $clog2(STORB_LEN);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  RESP_OKAY   = 3'b000;
  localparam logic [2:0]  RESP_SLVERR = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  function automatic logic f_in_range(input logic [ADDR_LEN-1:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> OFFB) < ADDR_LEN'(DEPTH));
  endfunction

  function automatic logic [IDXW-1:0] f_index(input logic [ADDR_LEN-1:0] a);
    return IDXW'((a - BASE_ADDR) >> OFFB);
  endfunction

  logic [DATA_LEN-1:0]  r_mem [DEPTH];

  logic                 r_aw_full;
  logic [ADDR_LEN-1:0]  r_aw_addr;
  logic                 r_w_full;
  logic [DATA_LEN-1:0]  r_wdata;
  logic [STORB_LEN-1:0] r_wstrb;
  wstate_t              r_wstate;
  wstate_t              w_wstate_nxt;
  logic [7:0]           r_wcnt;
  logic [7:0]           w_wcnt_nxt;
  logic                 w_wcommit;
  logic                 w_wclear;
  logic [2:0]           r_bresp;
  logic                 w_aw_inrange;
  logic [IDXW-1:0]      w_aw_idx;

  rstate_t              r_rstate;
  rstate_t              w_rstate_nxt;
  logic [7:0]           r_rcnt;
  logic [7:0]           w_rcnt_nxt;
  logic                 w_rsample;
  logic [ADDR_LEN-1:0]  r_ar_addr;
  logic [DATA_LEN-1:0]  r_rdata;
  logic [2:0]           r_rresp;
  logic                 w_ar_inrange;
  logic [IDXW-1:0]      w_ar_idx;

  assign w_aw_inrange = f_in_range(r_aw_addr);
  assign w_aw_idx     = f_index(r_aw_addr);
  assign w_ar_inrange = f_in_range(r_ar_addr);
  assign w_ar_idx     = f_index(r_ar_addr);

  // Write FSM: an incoming handshake counts as a full buffer so the wait starts on that edge.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    w_wcommit    = 1'b0;
    w_wclear     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if ((r_aw_full || awvalid) && (r_w_full || wvalid)) begin
          w_wstate_nxt = W_WAIT;
          w_wcnt_nxt   = 8'(WRITE_LAT);
        end
      end
      W_WAIT: begin
        if (r_wcnt == '0) begin
          w_wstate_nxt = W_RESP;
          w_wcommit    = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt - 8'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_wstate_nxt = W_IDLE;
          w_wclear     = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wstate  <= W_IDLE;
      r_wcnt    <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
      if (w_wclear) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (awvalid && !r_aw_full) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= waddr;
        end
        if (wvalid && !r_w_full) begin
          r_w_full <= 1'b1;
          r_wdata  <= wdata;
          r_wstrb  <= wstrob;
        end
      end
      if (w_wcommit) r_bresp <= w_aw_inrange ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Array is not reset; a read sampling on the commit edge sees the old word.
  always_ff @(posedge clk) begin
    if (w_wcommit && w_aw_inrange) begin
      for (int unsigned b = 0; b < STORB_LEN; b++) begin
        if (r_wstrb[b]) r_mem[w_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rcnt_nxt   = r_rcnt;
    w_rsample    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (arvalid) begin
          w_rstate_nxt = R_WAIT;
          w_rcnt_nxt   = 8'(READ_LAT);
        end
      end
      R_WAIT: begin
        if (r_rcnt == '0) begin
          w_rstate_nxt = R_RESP;
          w_rsample    = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt - 8'd1;
        end
      end
      R_RESP: begin
        if (rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= '0;
      r_ar_addr <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rcnt   <= w_rcnt_nxt;
      if (arvalid && (r_rstate == R_IDLE)) r_ar_addr <= raddr;
      if (w_rsample) begin
        r_rdata <= w_ar_inrange ? r_mem[w_ar_idx] : '0;
        r_rresp <= w_ar_inrange ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign awready = ~r_aw_full;
  assign wready  = ~r_w_full;
  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;
  assign arready = (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_sram_lat.sv
// Self-checking bench for axi_sram_lat: directed scenarios plus randomized write/read pairs
// checked against an associative-array memory model.
module tb_axi_sram_lat;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned RL    = 2;
  localparam int unsigned WL    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic [3:0]  wstrob;
  logic [2:0]  bresp, rresp;

  logic        z_awvalid, z_awready, z_wvalid, z_wready, z_bvalid, z_bready;
  logic        z_arvalid, z_arready, z_rvalid, z_rready;
  logic [31:0] z_waddr, z_wdata, z_raddr, z_rdata;
  logic [3:0]  z_wstrob;
  logic [2:0]  z_bresp, z_rresp;

  axi_sram_lat #(.DATA_LEN(32), .ADDR_LEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                 .READ_LAT(RL), .WRITE_LAT(WL)) u_dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .waddr(waddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrob(wstrob),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .raddr(raddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  axi_sram_lat #(.DATA_LEN(32), .ADDR_LEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                 .READ_LAT(0), .WRITE_LAT(0)) u_dut_z (
    .clk(clk), .rst(rst),
    .awvalid(z_awvalid), .awready(z_awready), .waddr(z_waddr),
    .wvalid(z_wvalid), .wready(z_wready), .wdata(z_wdata), .wstrob(z_wstrob),
    .bvalid(z_bvalid), .bready(z_bready), .bresp(z_bresp),
    .arvalid(z_arvalid), .arready(z_arready), .raddr(z_raddr),
    .rvalid(z_rvalid), .rready(z_rready), .rdata(z_rdata), .rresp(z_rresp)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] mdl [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    return (d >= 0) && ((d / 4) < longint'(DEPTH));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_in(a)) return 32'h0;
    return mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'hx;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    if (!m_in(a)) return;
    t = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'hx;
    for (int b = 0; b < 4; b++) if (s[b]) t[8*b +: 8] = d[8*b +: 8];
    mdl[m_idx(a)] = t;
  endfunction

  function automatic logic [2:0] m_resp(input logic [31:0] a);
    return m_in(a) ? 3'b000 : 3'b010;
  endfunction

  // All tasks start and end at posedge+1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int unsigned wd, input int unsigned bhold);
    int unsigned lat;
    logic [2:0]  eb;
    eb = m_resp(a);
    wvalid = 1'b1; wdata = d; wstrob = s;
    if (wd == 0) begin awvalid = 1'b1; waddr = a; end
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("wready_after_w_hs", 64'(wready), 64'(0));
    if (wd == 0) begin
      awvalid = 1'b0;
    end else begin
      for (int unsigned i = 1; i < wd; i++) begin @(posedge clk); #1; end
      chk("bvalid_before_aw", 64'(bvalid), 64'(0));
      awvalid = 1'b1; waddr = a;
      @(posedge clk); #1;
      awvalid = 1'b0;
    end
    chk("awready_after_aw_hs", 64'(awready), 64'(0));
    lat = 0;
    while (!bvalid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("b_latency", 64'(lat), 64'(WL + 1));
    chk("bresp", 64'(bresp), 64'(eb));
    for (int unsigned i = 0; i < bhold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 64'(bvalid), 64'(1));
      chk("bresp_hold", 64'(bresp), 64'(eb));
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_cleared", 64'(bvalid), 64'(0));
    chk("awready_reopen", 64'(awready), 64'(1));
    chk("wready_reopen", 64'(wready), 64'(1));
    m_write(a, d, s);
  endtask

  task automatic rd(input logic [31:0] a, input int unsigned hold);
    int unsigned lat;
    logic [31:0] ed;
    logic [2:0]  er;
    ed = m_read(a);
    er = m_resp(a);
    chk("arready_idle", 64'(arready), 64'(1));
    arvalid = 1'b1; raddr = a;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("arready_busy", 64'(arready), 64'(0));
    lat = 0;
    while (!rvalid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("r_latency", 64'(lat), 64'(RL + 1));
    chk("rdata", 64'(rdata), 64'(ed));
    chk("rresp", 64'(rresp), 64'(er));
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", 64'(rvalid), 64'(1));
      chk("rdata_hold", 64'(rdata), 64'(ed));
      chk("rresp_hold", 64'(rresp), 64'(er));
      chk("arready_hold", 64'(arready), 64'(0));
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_cleared", 64'(rvalid), 64'(0));
    chk("arready_after_r_hs", 64'(arready), 64'(1));
  endtask

  task automatic zwr(input logic [31:0] a, input logic [31:0] d);
    z_awvalid = 1'b1; z_waddr = a; z_wvalid = 1'b1; z_wdata = d; z_wstrob = 4'hF;
    @(posedge clk); #1;
    z_awvalid = 1'b0; z_wvalid = 1'b0;
    chk("z_bvalid_not_early", 64'(z_bvalid), 64'(0));
    @(posedge clk); #1;
    chk("z_b_latency0", 64'(z_bvalid), 64'(1));
    chk("z_bresp", 64'(z_bresp), 64'(0));
    z_bready = 1'b1;
    @(posedge clk); #1;
    z_bready = 1'b0;
  endtask

  task automatic zrd(input logic [31:0] a, input logic [31:0] ed);
    z_arvalid = 1'b1; z_raddr = a;
    @(posedge clk); #1;
    z_arvalid = 1'b0;
    chk("z_rvalid_not_early", 64'(z_rvalid), 64'(0));
    @(posedge clk); #1;
    chk("z_r_latency0", 64'(z_rvalid), 64'(1));
    chk("z_rdata", 64'(z_rdata), 64'(ed));
    z_rready = 1'b1;
    @(posedge clk); #1;
    z_rready = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, ra, z_old, z_new;
    logic [3:0]  s;

    rst = 1'b1;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    {z_awvalid, z_wvalid, z_bready, z_arvalid, z_rready} = '0;
    waddr = '0; wdata = '0; wstrob = '0; raddr = '0;
    z_waddr = '0; z_wdata = '0; z_wstrob = '0; z_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'(1));
    chk("rst_wready", 64'(wready), 64'(1));
    chk("rst_arready", 64'(arready), 64'(1));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous AW/W, full-word write then readback.
    wr(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0);
    rd(BASE, 0);

    // W four cycles ahead of AW, partial strobe over all-ones.
    wr(BASE + 4, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wr(BASE + 4, 32'h1122_3344, 4'b0101, 4, 2);
    chk("partial_strobe_model", 64'(m_read(BASE + 4)), 64'(32'hFF22_FF44));
    rd(BASE + 4, 0);

    // Out of range just past the array and just below the base.
    wr(BASE + DEPTH * 4, 32'h5555_AAAA, 4'hF, 0, 0);
    rd(BASE, 0);
    rd(BASE + DEPTH * 4, 0);
    rd(BASE - 4, 0);

    // Back-pressure on the read response.
    rd(BASE + 4, 10);

    for (int unsigned i = 0; i < 16; i++) wr(BASE + 4 * i, $urandom, 4'hF, 0, 0);

    // Zero strobe in range leaves the word untouched.
    wr(BASE + 8, 32'h0BAD_F00D, 4'h0, 1, 0);
    rd(BASE + 8, 0);
    rd(BASE + 12, 0);

    // Reset during W_WAIT with a read also pending.
    awvalid = 1'b1; waddr = BASE + 28; wvalid = 1'b1; wdata = 32'h7777_0000; wstrob = 4'hF;
    arvalid = 1'b1; raddr = BASE + 12;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_awready", 64'(awready), 64'(1));
    chk("mid_rst_wready", 64'(wready), 64'(1));
    chk("mid_rst_arready", 64'(arready), 64'(1));
    chk("mid_rst_bvalid", 64'(bvalid), 64'(0));
    chk("mid_rst_rvalid", 64'(rvalid), 64'(0));
    chk("mid_rst_bresp", 64'(bresp), 64'(0));
    chk("mid_rst_rresp", 64'(rresp), 64'(0));
    chk("mid_rst_rdata", 64'(rdata), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(BASE + 28, 0);
    wr(BASE + 28, 32'h0707_0707, 4'hF, 0, 0);
    rd(BASE + 28, 0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       a = BASE + DEPTH * 4 + $urandom_range(0, 63);
        1:       a = BASE - 4 * (1 + $urandom_range(0, 3));
        default: a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      endcase
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr(a, d, s, $urandom_range(0, 3), $urandom_range(0, 2));
      ra = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      rd(ra, $urandom_range(0, 2));
    end

    // Zero-latency instance: read sampling on the commit edge returns the old word.
    z_old = $urandom;
    z_new = ~z_old;
    zwr(BASE + 20, z_old);
    zrd(BASE + 20, z_old);
    z_awvalid = 1'b1; z_waddr = BASE + 20; z_wvalid = 1'b1; z_wdata = z_new; z_wstrob = 4'hF;
    z_arvalid = 1'b1; z_raddr = BASE + 20;
    @(posedge clk); #1;
    z_awvalid = 1'b0; z_wvalid = 1'b0; z_arvalid = 1'b0;
    @(posedge clk); #1;
    chk("z_collision_rvalid", 64'(z_rvalid), 64'(1));
    chk("z_collision_bvalid", 64'(z_bvalid), 64'(1));
    chk("z_collision_old_data", 64'(z_rdata), 64'(z_old));
    z_bready = 1'b1; z_rready = 1'b1;
    @(posedge clk); #1;
    z_bready = 1'b0; z_rready = 1'b0;
    zrd(BASE + 20, z_new);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_lat.md
# axi_sram_lat

Synthesizable AXI-lite-style memory slave with configurable depth, data width, base address and independent read/write response latency. Replaces the simulation-only DPI memory model on the core's memory bus with an on-chip register array. It adds back-pressure, out-of-range error responses and a deterministic latency, so the core's LSU and IFU stall paths are exercised identically in simulation and on FPGA.

## Interface
- DATA_LEN, 32, data width in bits; a multiple of 8, power of two.
- STORB_LEN, DATA_LEN/8, write strobe width, one bit per byte.
- ADDR_LEN, 32, address width.
- DEPTH, 1024, number of DATA_LEN-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LAT, 2, extra wait cycles before read data is presented (0..255).
- WRITE_LAT, 2, extra wait cycles before the write is committed (0..255).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- waddr  in  ADDR_LEN  write byte address.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wdata  in  DATA_LEN  write data.
- wstrob  in  STORB_LEN  byte enables; bit i enables wdata[8i+7:8i].
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- bresp  out  3  3'b000 OKAY, 3'b010 SLVERR.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- raddr  in  ADDR_LEN  read byte address.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rdata  out  DATA_LEN  read data, registered.
- rresp  out  3  same encoding as bresp.

## Operation
- Address decode:
  - index = (addr - BASE_ADDR) >> log2(STORB_LEN).
  - The address is in range iff addr >= BASE_ADDR and index < DEPTH.
  - The low log2(STORB_LEN) address bits are ignored (no misalignment error).
- Write path: separate one-entry AW and W holding buffers.
  - awready = AW buffer empty; wready = W buffer empty. The AW and W handshakes are accepted independently and in either order.
  - Write FSM W_IDLE -> W_WAIT -> W_RESP.
  - W_IDLE -> W_WAIT when both buffers are full; the wait counter loads WRITE_LAT.
  - W_WAIT decrements the counter. When the counter is 0, the FSM goes to W_RESP and, on the same edge, commits the write:
    - in range: the bytes with their strobe set are written;
    - out of range: nothing is written and bresp = SLVERR.
  - W_RESP holds bvalid = 1 and a stable bresp until bvalid&bready. On that edge both buffers are cleared and the FSM returns to W_IDLE.
  - wstrob = 0 in range: no byte changes, bresp = OKAY.
- Read path: FSM R_IDLE -> R_WAIT -> R_RESP.
  - arready = 1 only in R_IDLE.
  - arvalid&arready captures raddr and goes to R_WAIT, with the counter loaded with READ_LAT.
  - When the counter is 0, the FSM moves to R_RESP and registers the result:
    - in range: rdata = array word, rresp = OKAY;
    - out of range: rdata = 0, rresp = SLVERR.
  - R_RESP holds rvalid, rdata and rresp stable until rvalid&rready, then returns to R_IDLE.
- The read and write paths are fully independent and may be active simultaneously.
- Same-word collision: if a read samples the array on the same edge a write commits to that word, the read returns the old data (read-before-write).

## Timing
- Reset (asynchronous, while rst = 1):
  - awready = 1, wready = 1, arready = 1;
  - bvalid = 0, rvalid = 0;
  - bresp = 0, rresp = 0, rdata = 0;
  - all FSMs in idle, buffers empty, counters 0.
- The array contents are not reset.
- Reset asserted mid-transaction discards any uncommitted write and any pending read. Words already committed are kept.
- Read latency: rvalid rises READ_LAT+1 edges after the AR handshake edge. With READ_LAT = 0, rvalid is high the cycle after the handshake.
- Write latency: bvalid rises WRITE_LAT+1 edges after the later of the AW and W handshake edges. The array update is visible to a read sampling one edge later.
- Throughput:
  - reads: one per READ_LAT+2 cycles with rready held high;
  - writes: one per WRITE_LAT+3 cycles with bready held high.
- Back-pressure: while bvalid&~bready or rvalid&~rready, the corresponding FSM stalls indefinitely. The response outputs must not change.
- awready/wready fall on the edge after their respective handshake and rise on the bvalid&bready edge.

## Test plan
- Reset, then write 32'hDEAD_BEEF (wstrob 4'hF) to BASE_ADDR with awvalid and wvalid in the same cycle; read BASE_ADDR back -> bvalid after 3 cycles, bresp 0; rvalid 3 cycles after AR, rdata 32'hDEAD_BEEF, rresp 0.
- W sent 4 cycles before AW, wstrob 4'b0101, wdata 32'h1122_3344 over 32'hFFFF_FFFF -> wready low after the W handshake; bvalid WRITE_LAT+1 after AW; readback 32'hFF22_FF44.
- Write and read at BASE_ADDR + DEPTH*4 -> bresp 3'b010 with no array change (readback of word 0 unchanged); rdata 0 with rresp 3'b010.
- Hold rready = 0 for 10 cycles after rvalid -> rvalid, rdata and rresp constant and arready low; one cycle after rready = 1, arready = 1.
- READ_LAT = 0, WRITE_LAT = 0: issue a read of word 5 timed so it samples on the same edge that a write to word 5 commits -> read returns the old value; the next read returns the new value.
- Assert rst during W_WAIT of a write to word 7 -> all outputs at reset values immediately; word 7 retains its prior value; a following transaction completes normally.
